// File: rtl/rns2bin_32_17_13_11.sv
// Residue-to-binary converter for the moduli set {32, 17, 13, 11} using mixed-radix
// conversion, one digit per cycle: IDLE -> CAP -> D3 -> D4 -> SUM -> OUT.
module rns2bin_32_17_13_11 #(
    parameter int MOD_1    = 32,
    parameter int MOD_2    = 17,
    parameter int MOD_3    = 13,
    parameter int MOD_4    = 11,
    parameter int OUT_SIZE = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_mod_1,
    input  logic [4:0]          in_mod_2,
    input  logic [3:0]          in_mod_3,
    input  logic [3:0]          in_mod_4,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] out_bin,
    output logic                out_err,
    output logic [2:0]          state_dbg
);
    // Handshake: a transfer happens on the rising edge where valid && ready are both 1;
    // in_ready is high only in IDLE, out_valid only in OUT, and OUT data holds until taken.

    localparam logic [7:0] M2 = 8'(MOD_2);
    localparam logic [7:0] M3 = 8'(MOD_3);
    localparam logic [7:0] M4 = 8'(MOD_4);
    localparam logic [OUT_SIZE-1:0] W2 = OUT_SIZE'(MOD_1);
    localparam logic [OUT_SIZE-1:0] W3 = OUT_SIZE'(MOD_1 * MOD_2);
    localparam logic [OUT_SIZE-1:0] W4 = OUT_SIZE'(MOD_1 * MOD_2 * MOD_3);

    typedef enum logic [2:0] {IDLE, CAP, D3, D4, SUM, OUT} state_t;
    state_t state, state_next;

    logic [4:0] r2;
    logic [3:0] r3, r4;
    logic [7:0] a1, a2, a3, a4;
    logic [OUT_SIZE-1:0] sum;
    logic [7:0] a2_next, a3_next, a4_next;
    logic [7:0] u3, v3, u4, v4, w4;
    logic       err;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign state_dbg = state;
    assign err = (r2 >= 5'(MOD_2)) || (r3 >= 4'(MOD_3)) || (r4 >= 4'(MOD_4));

    // Each subtraction first adds a multiple of the modulus so no intermediate goes negative.
    always_comb begin
        a2_next = (((8'(in_mod_2) + 8'd2 * M2 - 8'(in_mod_1)) % M2) * 8'd8) % M2;
        u3      = (8'(r3) + 8'd3 * M3 - a1) % M3;
        v3      = ((u3 * 8'd11) % M3 + M3 - a2 % M3) % M3;
        a3_next = (v3 * 8'd10) % M3;
        u4      = (8'(r4) + 8'd3 * M4 - a1) % M4;
        v4      = ((u4 * 8'd10) % M4 + M4 - a2 % M4) % M4;
        w4      = ((v4 * 8'd2) + M4 - a3 % M4) % M4;
        a4_next = (w4 * 8'd6) % M4;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CAP;
            CAP:     state_next = D3;
            D3:      state_next = D4;
            D4:      state_next = SUM;
            SUM:     state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            r2      <= '0;
            r3      <= '0;
            r4      <= '0;
            a1      <= '0;
            a2      <= '0;
            a3      <= '0;
            a4      <= '0;
            sum     <= '0;
            out_bin <= '0;
            out_err <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) begin
                    r2 <= in_mod_2;
                    r3 <= in_mod_3;
                    r4 <= in_mod_4;
                    a1 <= 8'(in_mod_1);
                    a2 <= a2_next;
                end
                CAP: a3 <= a3_next;
                D3:  a4 <= a4_next;
                D4:  sum <= OUT_SIZE'(a1) + OUT_SIZE'(a2) * W2 + OUT_SIZE'(a3) * W3
                            + OUT_SIZE'(a4) * W4;
                SUM: begin
                    out_bin <= err ? '0 : sum;
                    out_err <= err;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rns2bin_32_17_13_11.sv
// Directed bench for rns2bin_32_17_13_11: latency, known vectors, backpressure,
// invalid residues, mid-conversion reset and a strided sweep of the dynamic range.
module tb_rns2bin_32_17_13_11;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mod_1;
    logic [4:0]  in_mod_2;
    logic [3:0]  in_mod_3;
    logic [3:0]  in_mod_4;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_bin;
    logic        out_err;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    rns2bin_32_17_13_11 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mod_1(in_mod_1), .in_mod_2(in_mod_2), .in_mod_3(in_mod_3), .in_mod_4(in_mod_4),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_err(out_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one tuple and returns #1 after the accept edge.
    task automatic send(input int r1, input int r2, input int r3, input int r4);
        @(negedge clk);
        check("ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_mod_1 = 5'(r1);
        in_mod_2 = 5'(r2);
        in_mod_3 = 4'(r3);
        in_mod_4 = 4'(r4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, checks latency/data, then the return to IDLE.
    task automatic expect_out(input string tag, input int exp_bin, input int exp_err);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_bin"}, 32'(out_bin), 32'(exp_bin));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        @(posedge clk);
        #1;
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_hold_in_idle"}, 32'(out_bin), 32'(exp_bin));
    endtask

    task automatic convert(input string tag, input int r1, input int r2, input int r3,
                           input int r4, input int exp_bin, input int exp_err);
        send(r1, r2, r3, r4);
        expect_out(tag, exp_bin, exp_err);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_mod_1  = '0;
        in_mod_2  = '0;
        in_mod_3  = '0;
        in_mod_4  = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bin", 32'(out_bin), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Known vectors
        convert("zero", 0, 0, 0, 0, 0, 0);
        convert("one", 1, 1, 1, 1, 1, 0);
        convert("max", 31, 16, 12, 10, 77791, 0);
        convert("v12345", 25, 3, 8, 3, 12345, 0);

        // Invalid residues (previous output nonzero, so out_bin=0 is meaningful)
        convert("bad_r2", 5, 17, 0, 0, 0, 1);
        convert("ok_mid", 25, 3, 8, 3, 12345, 0);
        convert("bad_r3", 5, 0, 13, 0, 0, 1);
        convert("bad_r4", 5, 0, 0, 11, 0, 1);
        convert("bad_r2_max", 31, 31, 15, 15, 0, 1);
        convert("after_bad", 1, 1, 1, 1, 1, 0);

        // Backpressure with in_valid held high and inputs changed while busy
        out_ready = 1'b0;
        send(25, 3, 8, 3);
        in_valid = 1'b1;
        in_mod_1 = 5'd1;
        in_mod_2 = 5'd1;
        in_mod_3 = 4'd1;
        in_mod_4 = 4'd1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("bp_busy_ready", 32'(in_ready), 32'd0);
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_bin", 32'(out_bin), 32'd12345);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_bin", 32'(out_bin), 32'd12345);
            check("bp_hold_err", 32'(out_err), 32'd0);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accept", 32'(in_ready), 32'd0);
        expect_out("bp_second", 1, 0);

        // Reset pulsed in D3
        convert("pre_reset", 31, 16, 12, 10, 77791, 0);
        send(25, 3, 8, 3);
        @(posedge clk);
        #1;
        check("rst_mid_state_d3", 32'(state_dbg), 32'd2);
        reset = 1'b0;
        #1;
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_bin", 32'(out_bin), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_hold_ready", 32'(in_ready), 32'd1);
        check("rst_mid_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("rst_abort_no_out", 32'(out_valid), 32'd0);
        end
        convert("post_reset", 25, 3, 8, 3, 12345, 0);

        // Strided sweep of the range, plus the top value
        for (int x = 0; x < 77792; x += 97)
            convert("sweep", x % 32, x % 17, x % 13, x % 11, x, 0);
        convert("sweep_top", 77791 % 32, 77791 % 17, 77791 % 13, 77791 % 11, 77791, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
